uart_msg_tx: RTL and testbench
==============================

Name: uart_msg_tx

Overview:
Parametrised UART message transmitter. It serialises a fixed ASCII template of MSG_LEN characters at a configurable baud divisor. One template character can be replaced at run time by a caller-supplied byte, which generalises the single pick/deposit letter to any field. It adds a start/busy/done handshake, so the bot controller launches one message per request and knows when the line is free. The block drives the serial line to the XBee/Hterm link from the 50 MHz domain.

Parameters:
CLK_DIV, 434, clk_50 cycles per serial bit (115200 baud at 50 MHz); legal range 2..1023
MSG_LEN, 13, characters per message; legal range 1..64
MSG, "S_P_DZN1_N_#\n", template, MSG_LEN*8 bits; first character sent = MSG[MSG_LEN*8-1 -: 8]
SUB_POS, 3, 1-based position (1 = first character sent) of the substituted character; 0 = no substitution

Ports:
clk_50  input  1  system clock
rst  input  1  synchronous reset, active-high
start  input  1  request one message; sampled on rising clk_50
sub_char  input  8  replacement byte for position SUB_POS; latched when start is accepted
tx  output  1  UART serial out, idle high, LSB first
busy  output  1  high from the cycle after start is accepted until done
done  output  1  single-cycle pulse after the last stop bit completes

Behaviour:
- One clock is used: clk_50. Reset is synchronous and active-high on rst. When rst is sampled high: state=IDLE, tx=1, busy=0, done=0, and the bit timer, bit index, char index and latched sub byte are all cleared. This applies mid-frame too: tx returns high the cycle after rst, and no partial character resumes.
- All outputs are registered.
- The FSM has four states: IDLE, START, DATA, STOP.
- IDLE: tx=1. start=1 is accepted here. On acceptance: latch sub_char, set char index=0, load the first character, move to START, busy=1 next cycle.
- start while busy is ignored. It does not restart the message (a deliberate change from the retrigger-resets behaviour).
- START: tx=0 for exactly CLK_DIV cycles, then go to DATA with bit index=0.
- DATA: tx=char[bit index]. Each bit lasts CLK_DIV cycles. After bit 7, go to STOP (or to PARITY when the optional feature is compiled in).
- STOP: tx=1 for CLK_DIV cycles.
  - If more characters remain: increment char index, load the next character, and go to START in the next cycle. There is no idle gap between characters.
  - If this was the last character: go to IDLE, busy=0 and done=1 in the same cycle, done cleared the following cycle.
- Latency: start sampled at edge t gives tx falling at edge t+1. busy also rises at t+1.
- Character selection: position k (1-based) = MSG[(MSG_LEN-k+1)*8-1 -: 8]. If k==SUB_POS and SUB_POS!=0, the latched sub_char is sent instead.
- A change on sub_char after acceptance has no effect on the current message.
- Message duration from the first tx fall to the done pulse = MSG_LEN*FRAME*CLK_DIV cycles, where FRAME=10 (11 with parity). Default: 13*10*434 = 56420 cycles.
- start held high continuously: a new message is accepted the cycle after done, i.e. on the first IDLE cycle.
- Bit timer width = clog2(CLK_DIV). The timer counts 0..CLK_DIV-1 and wraps to 0 at every bit boundary.
- Char index width = clog2(MSG_LEN+1).
- Parameter values outside the legal ranges are unsupported.

Optional Feature:
Macro UART_PARITY_EN.
- When defined: a PARITY state is inserted between DATA and STOP. It drives even parity (XOR of the 8 data bits) for CLK_DIV cycles. FRAME=11.
- When undefined: no PARITY state and FRAME=10. Ports are identical in both builds.

Test Plan:
- Basic frame: CLK_DIV=4, MSG_LEN=2, MSG="A\n", SUB_POS=0, pulse start → tx bits 0,1,0,0,0,0,0,1,0,1 (0x41) then 0,0,1,0,1,0,0,0,0,1 (0x0A). Each bit lasts 4 cycles. done pulses at 80 cycles after the first tx fall; busy high for exactly those 80 cycles.
- Substitution: default MSG, SUB_POS=3, sub_char=0x44 ('D'), CLK_DIV=4 → third decoded character is 'D', all others match "S_?_DZN1_N_#\n". Change sub_char mid-message → no effect on the message in flight.
- Busy ignore: pulse start again 100 cycles into a message → no restart; total duration is still MSG_LEN*40 cycles and a single done pulse occurs.
- Reset mid-frame: assert rst during DATA of character 5 → next cycle tx=1, busy=0, done=0. A subsequent start sends the full message from character 1.
- Back-to-back: start held high → second message's start bit begins the cycle after the first done. There is no gap between stop and start bits within a message.
- Parity (UART_PARITY_EN): send 'A' (0x41, two ones) → parity bit 0. Send 'C' (0x43, three ones) → parity bit 1. Frame is 11 bits.

Source files
------------

// File: rtl/uart_msg_tx_if.sv
// Request/status handshake and serial line of uart_msg_tx.
// master = bot controller side, slave = transmitter side.
interface uart_msg_tx_if ();
  logic       start;
  logic [7:0] sub_char;
  logic       tx;
  logic       busy;
  logic       done;

  modport master (
    output start,
    output sub_char,
    input  tx,
    input  busy,
    input  done
  );

  modport slave (
    input  start,
    input  sub_char,
    output tx,
    output busy,
    output done
  );
endinterface

// File: rtl/uart_msg_tx.sv
// UART message transmitter: serialises a fixed ASCII template, one character optionally
// replaced by a byte latched at start. Define UART_PARITY_EN to append an even-parity bit.
module uart_msg_tx #(
  parameter int                   CLK_DIV = 434,
  parameter int                   MSG_LEN = 13,
  parameter logic [MSG_LEN*8-1:0] MSG     = "S_P_DZN1_N_#\n",
  parameter int                   SUB_POS = 3
) (
  input  logic         clk_50,
  input  logic         rst,
  uart_msg_tx_if.slave bus
);

  localparam int TIMER_W = $clog2(CLK_DIV);
  localparam int CHAR_W  = $clog2(MSG_LEN + 1);

  localparam logic [TIMER_W-1:0] TIMER_MAX = TIMER_W'(CLK_DIV - 1);
  localparam logic [CHAR_W-1:0]  LAST_CHAR = CHAR_W'(MSG_LEN - 1);
  localparam bit                 SUB_EN    = (SUB_POS != 0);
  localparam logic [CHAR_W-1:0]  SUB_IDX   = CHAR_W'(SUB_EN ? SUB_POS - 1 : 0);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_PARITY_EN
    PARITY,
`endif
    STOP
  } state_e;

  state_e               state_q, state_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic [CHAR_W-1:0]    char_idx_q, char_idx_d;
  logic [7:0]           char_q, char_d;
  logic [7:0]           sub_q, sub_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic                 bit_end;
  logic [CHAR_W-1:0]    char_idx_next;

  // Character at 0-based index idx; the template is stored first-character-in-MSB.
  function automatic logic [7:0] char_sel(input logic [CHAR_W-1:0] idx,
                                          input logic [7:0]        sub);
    logic [MSG_LEN*8-1:0] shifted;
    shifted = MSG << {idx, 3'b000};
    if (SUB_EN && idx == SUB_IDX) return sub;
    return shifted[MSG_LEN*8-1 -: 8];
  endfunction

  assign bit_end       = (timer_q == TIMER_MAX);
  assign char_idx_next = char_idx_q + CHAR_W'(1);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_50) begin
    if (rst) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      bit_idx_q  <= '0;
      char_idx_q <= '0;
      char_q     <= '0;
      sub_q      <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      bit_idx_q  <= bit_idx_d;
      char_idx_q <= char_idx_d;
      char_q     <= char_d;
      sub_q      <= sub_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // NOTE: every signal gets a default at the top of a combinational block so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    bit_idx_d  = bit_idx_q;
    char_idx_d = char_idx_q;
    char_d     = char_q;
    sub_d      = sub_q;

    if (state_q != IDLE) timer_d = bit_end ? '0 : timer_q + TIMER_W'(1);

    unique case (state_q)
      IDLE: begin
        // start while busy never reaches here, so a request cannot retrigger a message.
        if (bus.start) begin
          sub_d      = bus.sub_char;
          char_idx_d = '0;
          char_d     = char_sel('0, bus.sub_char);
          timer_d    = '0;
          state_d    = START;
        end
      end
      START: begin
        if (bit_end) begin
          bit_idx_d = '0;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_idx_q == 3'd7) begin
`ifdef UART_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
`ifdef UART_PARITY_EN
      PARITY: begin
        if (bit_end) state_d = STOP;
      end
`endif
      STOP: begin
        if (bit_end) begin
          if (char_idx_q == LAST_CHAR) begin
            state_d = IDLE;
          end else begin
            char_idx_d = char_idx_next;
            char_d     = char_sel(char_idx_next, sub_q);
            state_d    = START;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs follow the current state one cycle later, giving the start-to-tx latency.
  always_comb begin
    tx_d   = 1'b1;
    busy_d = (state_q != IDLE);
    done_d = (state_q == IDLE) && busy_q;
    case (state_q)
      START:   tx_d = 1'b0;
      DATA:    tx_d = char_q[bit_idx_q];
`ifdef UART_PARITY_EN
      PARITY:  tx_d = ^char_q;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  assign bus.tx   = tx_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_uart_msg_tx.sv
// Self-checking bench for uart_msg_tx: two instances (short template without substitution,
// default template with substitution at position 3), randomized sub bytes and start timing.
module tb_uart_msg_tx;

  localparam int TB_DIV = 4;
`ifdef UART_PARITY_EN
  localparam int FRAME = 11;
`else
  localparam int FRAME = 10;
`endif

  logic clk_50 = 1'b0;
  logic rst    = 1'b1;
  int   n_cmp  = 0;
  int   n_err  = 0;

  string tmpl_a = "A\n";
  string tmpl_b = "S_P_DZN1_N_#\n";

  uart_msg_tx_if bus_a ();
  uart_msg_tx_if bus_b ();

  uart_msg_tx #(.CLK_DIV(TB_DIV), .MSG_LEN(2), .MSG("A\n"), .SUB_POS(0)) dut_a (
    .clk_50(clk_50),
    .rst   (rst),
    .bus   (bus_a)
  );

  uart_msg_tx #(.CLK_DIV(TB_DIV)) dut_b (
    .clk_50(clk_50),
    .rst   (rst),
    .bus   (bus_b)
  );

  always #5 clk_50 = ~clk_50;

  logic [1:0] tx_v, busy_v, done_v;
  assign tx_v   = {bus_b.tx,   bus_a.tx};
  assign busy_v = {bus_b.busy, bus_a.busy};
  assign done_v = {bus_b.done, bus_a.done};

  task automatic drive_start(input int sel, input logic v);
    if (sel == 1) bus_b.start = v;
    else          bus_a.start = v;
  endtask

  task automatic drive_sub(input int sel, input logic [7:0] v);
    if (sel == 1) bus_b.sub_char = v;
    else          bus_a.sub_char = v;
  endtask

  // Single start pulse accepted at the next rising edge (DUT must be idle).
  task automatic launch(input int sel, input logic [7:0] sub);
    @(negedge clk_50);
    drive_sub(sel, sub);
    drive_start(sel, 1'b1);
    @(posedge clk_50);
    #1 drive_start(sel, 1'b0);
  endtask

  // Idle line for n cycles: tx high, busy and done low.
  task automatic check_quiet(input int sel, input int n, input string name);
    logic bad;
    logic [2:0] seen;
    bad  = 1'b0;
    seen = 3'b100;
    for (int i = 0; i < n; i++) begin
      @(negedge clk_50);
      if ({tx_v[sel], busy_v[sel], done_v[sel]} !== 3'b100 && !bad) begin
        bad  = 1'b1;
        seen = {tx_v[sel], busy_v[sel], done_v[sel]};
      end
    end
    n_cmp++;
    if (bad) begin
      n_err++;
      $display("FAIL %s: tx/busy/done=%b, expected 100 for %0d cycles", name, seen, n);
    end
  endtask

  // Reference model: called right after the accepting edge (or, with skip_lat, at the
  // negedge of the previous done). Expects the UART frame of each template character,
  // with position sub_pos replaced by sub, then a one-cycle done with busy low.
  task automatic watch_msg(input int sel, input string tmpl, input int sub_pos,
                           input logic [7:0] sub, input bit skip_lat, input string name);
    logic [7:0]        c;
    logic              fb [FRAME];
    logic [TB_DIV-1:0] got_tx;
    logic              all_busy, any_done;
    if (!skip_lat) begin
      @(negedge clk_50);
      n_cmp++;
      if ({tx_v[sel], busy_v[sel]} !== 2'b10) begin
        n_err++;
        $display("FAIL %s latency: tx/busy=%b%b, expected 10", name, tx_v[sel], busy_v[sel]);
      end
    end
    for (int k = 0; k < tmpl.len(); k++) begin
      c = tmpl[k];
      if (k + 1 == sub_pos) c = sub;
      fb[0] = 1'b0;
      for (int i = 0; i < 8; i++) fb[1+i] = c[i];
`ifdef UART_PARITY_EN
      fb[9] = ^c;
`endif
      fb[FRAME-1] = 1'b1;
      for (int b = 0; b < FRAME; b++) begin
        all_busy = 1'b1;
        any_done = 1'b0;
        for (int s = 0; s < TB_DIV; s++) begin
          @(negedge clk_50);
          got_tx[s] = tx_v[sel];
          all_busy  = all_busy & busy_v[sel];
          any_done  = any_done | done_v[sel];
        end
        n_cmp++;
        if (got_tx !== {TB_DIV{fb[b]}} || all_busy !== 1'b1 || any_done !== 1'b0) begin
          n_err++;
          $display("FAIL %s char %0d (0x%02h) bit %0d: tx=%b busy=%b done=%b, expected tx=%b busy=1 done=0",
                   name, k + 1, c, b, got_tx, all_busy, any_done, {TB_DIV{fb[b]}});
        end
      end
    end
    @(negedge clk_50);
    n_cmp++;
    if ({tx_v[sel], busy_v[sel], done_v[sel]} !== 3'b101) begin
      n_err++;
      $display("FAIL %s end: tx/busy/done=%b%b%b, expected 101", name,
               tx_v[sel], busy_v[sel], done_v[sel]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_start(0, 1'b0); drive_start(1, 1'b0);
    drive_sub(0, 8'h00);  drive_sub(1, 8'h00);
    repeat (3) @(posedge clk_50);
    @(negedge clk_50);
    n_cmp++;
    if ({tx_v, busy_v, done_v} !== 6'b11_00_00) begin
      n_err++;
      $display("FAIL reset_state: tx=%b busy=%b done=%b, expected tx=11 busy=00 done=00",
               tx_v, busy_v, done_v);
    end
    rst = 1'b0;
    check_quiet(0, 5, "reset_idle_a");
    check_quiet(1, 5, "reset_idle_b");
  endtask

  task automatic test_basic_frame();
    logic [7:0] sub;
    launch(0, 8'h00);
    watch_msg(0, tmpl_a, 0, 8'h00, 1'b0, "basic");
    check_quiet(0, 3, "basic_after");
    sub = 8'($urandom_range(0, 255));
    launch(0, sub);
    watch_msg(0, tmpl_a, 0, sub, 1'b0, "basic_no_sub");
    check_quiet(0, 1, "basic_no_sub_after");
  endtask

  task automatic test_substitution();
    logic [7:0] sub;
    for (int it = 0; it < 3; it++) begin
      sub = (it == 0) ? 8'h44 : 8'($urandom_range(0, 255));
      launch(1, sub);
      fork
        watch_msg(1, tmpl_b, 3, sub, 1'b0, "subst");
        begin
          for (int j = 0; j < 8; j++) begin
            repeat ($urandom_range(20, 60)) @(negedge clk_50);
            drive_sub(1, 8'($urandom_range(0, 255)));
          end
        end
      join
      check_quiet(1, 1, "subst_after");
    end
  endtask

  task automatic test_busy_ignore();
    logic [7:0] sub;
    sub = 8'($urandom_range(0, 255));
    launch(1, sub);
    fork
      watch_msg(1, tmpl_b, 3, sub, 1'b0, "busy_ignore");
      begin
        repeat (100) @(negedge clk_50);
        drive_sub(1, ~sub);
        drive_start(1, 1'b1);
        @(negedge clk_50);
        drive_start(1, 1'b0);
        repeat ($urandom_range(50, 300)) @(negedge clk_50);
        drive_start(1, 1'b1);
        @(negedge clk_50);
        drive_start(1, 1'b0);
      end
    join
    check_quiet(1, 20, "busy_ignore_single_done");
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] sub, c5;
    sub = 8'($urandom_range(0, 255));
    c5  = tmpl_b[4];
    launch(1, sub);
    // Land on the third sample of data bit 1 of character 5.
    repeat (1 + 4 * FRAME * TB_DIV + 2 * TB_DIV + 3) @(negedge clk_50);
    n_cmp++;
    if ({tx_v[1], busy_v[1]} !== {c5[1], 1'b1}) begin
      n_err++;
      $display("FAIL mid_frame_pre_reset: tx/busy=%b%b, expected %b1", tx_v[1], busy_v[1], c5[1]);
    end
    rst = 1'b1;
    @(posedge clk_50);
    @(negedge clk_50);
    n_cmp++;
    if ({tx_v[1], busy_v[1], done_v[1]} !== 3'b100) begin
      n_err++;
      $display("FAIL mid_frame_reset: tx/busy/done=%b%b%b, expected 100",
               tx_v[1], busy_v[1], done_v[1]);
    end
    rst = 1'b0;
    check_quiet(1, 2 * FRAME * TB_DIV, "reset_no_resume");
    sub = 8'($urandom_range(0, 255));
    launch(1, sub);
    watch_msg(1, tmpl_b, 3, sub, 1'b0, "after_reset");
    check_quiet(1, 1, "after_reset_idle");
  endtask

  task automatic test_back_to_back();
    logic [7:0] sub1, sub2;
    @(negedge clk_50);
    drive_start(0, 1'b1);
    @(posedge clk_50);
    watch_msg(0, tmpl_a, 0, 8'h00, 1'b0, "b2b_a1");
    drive_start(0, 1'b0);
    watch_msg(0, tmpl_a, 0, 8'h00, 1'b1, "b2b_a2");
    check_quiet(0, 5, "b2b_a_after");

    sub1 = 8'($urandom_range(0, 255));
    sub2 = 8'($urandom_range(0, 255));
    @(negedge clk_50);
    drive_sub(1, sub1);
    drive_start(1, 1'b1);
    @(posedge clk_50);
    fork
      watch_msg(1, tmpl_b, 3, sub1, 1'b0, "b2b_b1");
      begin
        repeat (200) @(negedge clk_50);
        drive_sub(1, sub2);
      end
    join
    drive_start(1, 1'b0);
    watch_msg(1, tmpl_b, 3, sub2, 1'b1, "b2b_b2");
    check_quiet(1, 5, "b2b_b_after");
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_substitution();
    test_busy_ignore();
    test_reset_mid_frame();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected bench to finish");
    $fatal(1, "watchdog expired");
  end

endmodule
